// File: rtl/gshare_spec_predictor_pkg.sv
// Shared types and helpers for the gshare predictor: FSM states, index and
// history-shift functions, default counter init value.
package gshare_pkg;

  typedef enum logic {GS_INIT = 1'b0, GS_READY = 1'b1} gs_state_e;

  // Weakly not-taken for 2-bit counters.
  localparam int GS_CTR_INIT = 1;

  // Shift history right by one, new outcome enters at bit hb-1 (the MSB).
  // Upper bits of h above hb are expected to be zero.
  function automatic logic [31:0] gs_hist_shift(logic [31:0] h, logic b, int unsigned hb);
    return (h >> 1) | (32'(b) << (hb - 1));
  endfunction

  // idx = pc[sel:1] ^ zero-extended history, masked to sel bits.
  function automatic logic [63:0] gs_index(logic [63:0] pc, logic [31:0] h, int unsigned sel);
    return ((pc >> 1) ^ 64'(h)) & ((64'd1 << sel) - 64'd1);
  endfunction

endpackage

// File: rtl/gshare_spec_predictor_sat_counter.sv
// Saturating up/down counter next-value logic.
module sat_counter #(
  parameter int CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] ctr_i,
  input  logic                taken_i,
  output logic [CTR_BITS-1:0] ctr_o
);

  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

  // Step toward the resolved direction, holding at either rail.
  always_comb begin
    ctr_o = ctr_i;
    if (taken_i && (ctr_i != CTR_MAX))
      ctr_o = ctr_i + 1'b1;
    else if (!taken_i && (ctr_i != '0))
      ctr_o = ctr_i - 1'b1;
  end

endmodule

// File: rtl/gshare_spec_predictor.sv
// gshare direction predictor with speculative global history, multi-port
// in-cycle history chaining and a post-reset table init sweep.
// Optional macro GSHARE_BYPASS_EN: forward a same-cycle update to a
// prediction port reading the same entry.
import gshare_pkg::*;

module gshare_spec_predictor #(
  parameter int PC_BITS      = 32,
  parameter int HISTORY_BITS = 8,
  parameter int SIZE         = 1024,
  parameter int CTR_BITS     = 2,
  parameter int RD_PORTS     = 2,
  parameter int CTR_INIT     = GS_CTR_INIT
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  output logic                                   ready,
  input  logic [RD_PORTS-1:0][PC_BITS-1:0]       pc_in,
  input  logic [RD_PORTS-1:0]                    pred_valid_in,
  output logic [RD_PORTS-1:0]                    is_taken_out,
  output logic [RD_PORTS-1:0][HISTORY_BITS-1:0]  hist_out,
  input  logic                                   wr_en,
  input  logic [PC_BITS-1:0]                     orig_pc,
  input  logic [HISTORY_BITS-1:0]                upd_hist,
  input  logic                                   is_taken,
  input  logic                                   flush_valid,
  input  logic [HISTORY_BITS-1:0]                flush_hist,
  input  logic                                   flush_taken
);

  localparam int SEL_BITS = $clog2(SIZE);

  gs_state_e                state_q, state_d;
  logic [SEL_BITS-1:0]      sweep_q, sweep_d;
  logic [HISTORY_BITS-1:0]  spec_hist_q, spec_hist_d;
  logic [CTR_BITS-1:0]      table_q [SIZE];

  logic [SEL_BITS-1:0]      upd_idx;
  logic [CTR_BITS-1:0]      upd_cur, upd_next;
  logic                     upd_act;

  logic [HISTORY_BITS-1:0]  rd_hist;
  logic [SEL_BITS-1:0]      rd_idx;
  logic [CTR_BITS-1:0]      rd_ctr;
  logic                     rd_tk;

  assign ready   = (state_q == GS_READY);
  assign upd_act = ready && wr_en;
  assign upd_idx = SEL_BITS'(gs_index(64'(orig_pc), 32'(upd_hist), SEL_BITS));
  assign upd_cur = table_q[upd_idx];

  // One counter step serves the table write and, when enabled, forwarding.
  sat_counter #(.CTR_BITS(CTR_BITS)) u_upd_ctr (
    .ctr_i   (upd_cur),
    .taken_i (is_taken),
    .ctr_o   (upd_next)
  );

  // Init sweep: one entry per cycle, then hand over to normal operation.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (state_q == GS_INIT) begin
      sweep_d = sweep_q + 1'b1;
      if (sweep_q == SEL_BITS'(SIZE - 1)) state_d = GS_READY;
    end
  end

  // FSM, sweep pointer and speculative history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= GS_INIT;
      sweep_q     <= '0;
      spec_hist_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      spec_hist_q <= spec_hist_d;
    end
  end

  // Counter table: sweep writes during init, resolve updates afterwards.
  always_ff @(posedge clk) begin
    if (state_q == GS_INIT)
      table_q[sweep_q] <= CTR_BITS'(CTR_INIT);
    else if (wr_en)
      table_q[upd_idx] <= upd_next;
  end

  // Per-port reads, history chained through older ports, next spec history.
  always_comb begin
    rd_hist      = spec_hist_q;
    rd_idx       = '0;
    rd_ctr       = '0;
    rd_tk        = 1'b0;
    hist_out     = '0;
    is_taken_out = '0;
    for (int i = 0; i < RD_PORTS; i++) begin
      hist_out[i] = rd_hist;
      rd_idx = SEL_BITS'(gs_index(64'(pc_in[i]), 32'(rd_hist), SEL_BITS));
      rd_ctr = table_q[rd_idx];
`ifdef GSHARE_BYPASS_EN
      if (upd_act && (rd_idx == upd_idx)) rd_ctr = upd_next;
`endif
      rd_tk = ready & rd_ctr[CTR_BITS-1];
      is_taken_out[i] = rd_tk;
      if (pred_valid_in[i])
        rd_hist = HISTORY_BITS'(gs_hist_shift(32'(rd_hist), rd_tk, HISTORY_BITS));
    end
    // Recovery wins over any predictions committed this cycle.
    if (ready && flush_valid)
      spec_hist_d = HISTORY_BITS'(gs_hist_shift(32'(flush_hist), flush_taken, HISTORY_BITS));
    else
      spec_hist_d = rd_hist;
  end

endmodule

// File: doc/gshare_spec_predictor.md
Name: gshare_spec_predictor

Overview:
- Next-generation gshare direction predictor.
- Provides RD_PORTS parallel prediction ports and per-port indexing of PC XOR global history.
- Keeps a speculative global history with per-branch history snapshots and flush recovery.
- Uses parametrised saturating counters; the table is initialised by a post-reset sweep FSM instead of a resettable array.
- Sits in the fetch-stage branch predictor beside the BTB. Updates and flushes come from the branch-resolve stage.

Parameters:
- PC_BITS, 32, PC address width.
- HISTORY_BITS, 8, global history length; must be <= $clog2(SIZE).
- SIZE, 1024, counter entries; power of 2; SEL_BITS = $clog2(SIZE).
- CTR_BITS, 2, saturating counter width, >= 2.
- RD_PORTS, 2, prediction ports; port 0 is oldest in program order.
- CTR_INIT, 1, counter value written by the init sweep (weakly not-taken).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ready  out  1  high once the init sweep is done
- pc_in  in  [RD_PORTS][PC_BITS]  prediction PCs
- pred_valid_in  in  [RD_PORTS]  port holds a real conditional branch; commits its prediction into speculative history
- is_taken_out  out  [RD_PORTS]  predicted direction (counter MSB)
- hist_out  out  [RD_PORTS][HISTORY_BITS]  history used for this port's index; carried with the branch
- wr_en  in  1  resolve update valid
- orig_pc  in  PC_BITS  resolved branch PC
- upd_hist  in  HISTORY_BITS  hist_out snapshot the branch was predicted with
- is_taken  in  1  resolved direction
- flush_valid  in  1  misprediction recovery
- flush_hist  in  HISTORY_BITS  snapshot of the mispredicted branch
- flush_taken  in  1  its correct direction

Behaviour:
- Index. idx(pc,h) = pc[SEL_BITS:1] XOR zero-extended h. The table holds one CTR_BITS counter per entry.
- Reads. Asynchronous and combinational: prediction appears in the same cycle as pc_in.
- History chaining within a cycle:
  - hist_out[0] = spec_hist.
  - hist_out[i] = hist_out[i-1] shifted, i.e. {is_taken_out[i-1], hist_out[i-1][H-1:1]}, when pred_valid_in[i-1]; otherwise hist_out[i] = hist_out[i-1].
- Shift rule everywhere: the new bit enters at the MSB.
- spec_hist next edge:
  - If flush_valid: {flush_taken, flush_hist[H-1:1]}. Flush overrides all pred_valid_in in the same cycle.
  - Otherwise: hist_out[RD_PORTS-1] further shifted by the last port if pred_valid_in[RD_PORTS-1].
- Update (wr_en), read-modify-write in one cycle:
  - Entry: idx(orig_pc, upd_hist).
  - Taken: increment, saturating at 2^CTR_BITS-1. Not-taken: decrement, saturating at 0.
  - The write takes effect at the next edge; the update never touches spec_hist.
- Flush and wr_en in the same cycle are independent; both are applied.
- Same-cycle read and update of one entry: the read returns the pre-update value (see the optional feature).
- FSM states INIT and READY:
  - Reset enters INIT with sweep counter 0.
  - INIT writes CTR_INIT to one entry per cycle, 0 up to SIZE-1, then moves to READY after SIZE cycles.
  - In INIT, wr_en and flush_valid are ignored and is_taken_out is forced to 0.
  - Reset asserted mid-sweep or in READY restarts INIT from entry 0.
- Reset values:
  - ready = 0, spec_hist = 0, is_taken_out = 0, hist_out[i] = 0.
  - Array contents are undefined until the sweep completes.

Optional Feature:
- Macro: GSHARE_BYPASS_EN.
- Defined: a prediction port whose index equals the active update index in that cycle returns the updated counter MSB (write-to-read forwarding).
- Undefined: it returns the stored pre-update value. No other behaviour changes.

Decomposition:
- Package gshare_pkg holds:
  - the FSM state enum (GS_INIT, GS_READY);
  - the history shift function;
  - the index function;
  - the CTR_INIT default constant.
- Sub-module sat_counter (parameter CTR_BITS) computes the saturating next value. It is instantiated for the update path and for the bypass path.

Test Plan:
- Reset, SIZE=1024 -> ready low exactly 1024 cycles then high. Any pc predicts 0 afterwards (counter 1). wr_en during INIT leaves entries at 1.
- Train pc 0x100, upd_hist 0x00, is_taken=1 x3 -> counter 1,2,3,3. Predicting 0x100 with spec_hist 0x00 gives 1 after the first update.
- Not-taken x2 on a fresh entry -> 1,0,0 (low saturation). Prediction stays 0.
- Chaining: spec_hist 0x00, port0 predicts taken, pred_valid_in=2'b11, port1 predicts 0 -> hist_out[1]=0x80. Next spec_hist=0x40.
- Flush with flush_hist 0x55, flush_taken 1, alongside pred_valid_in=2'b11 -> next spec_hist 0xAA, predictions ignored. A simultaneous wr_en still updates its entry.
- Same-cycle update and read of one entry at counter 1 with is_taken=1 -> predicts 1 with GSHARE_BYPASS_EN defined, 0 without it.
